// File: rtl/st7920_pkg.sv
// Shared types, frame constants and opcode helpers for the ST7920 serial command path.
// No logic of its own.
package st7920_pkg;

    localparam int         FRAME_BITS = 24;
    localparam logic [4:0] SYNC       = 5'b11111;

    // Instructions that keep the controller busy for ~1.6 ms instead of ~72 us
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } st7920_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } sched_state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input st7920_cmd_t c);
        return {SYNC, c.rw, c.rs, 1'b0, c.data[7:4], 4'b0000, c.data[3:0], 4'b0000};
    endfunction

    function automatic logic is_long_cmd(input st7920_cmd_t c);
        return !c.rs && !c.rw &&
               (c.data == OP_CLEAR || c.data == OP_HOME || c.data == OP_HOME_ALT);
    endfunction

endpackage

// File: rtl/st7920_frame_tx.sv
// Shifts one 24-bit ST7920 frame MSB first, 2*CLK_DIV cycles per bit; frame starts the cycle after start.
// No backpressure: start is only honoured when idle, done pulses in the last cycle of the last bit.
module st7920_frame_tx
    import st7920_pkg::*;
#(
    parameter int CLK_DIV = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  st7920_cmd_t cmd,
    output logic        done,
    output logic        lcd_cs,
    output logic        lcd_clk,
    output logic        lcd_data
);

    localparam int PH_W  = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] frame;
    logic [FRAME_BITS-1:0] shreg;
    logic [PH_W-1:0]       ph_cnt;
    logic [BIT_W-1:0]      bit_cnt;

    assign frame = build_frame(cmd);
    assign done  = lcd_cs && (ph_cnt == PH_LAST) && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            ph_cnt   <= '0;
            bit_cnt  <= '0;
            lcd_cs   <= 1'b0;
            lcd_clk  <= 1'b0;
            lcd_data <= 1'b0;
        end else if (start && !lcd_cs) begin
            // First bit goes straight onto SID; shreg holds the remaining bits
            shreg    <= {frame[FRAME_BITS-2:0], 1'b0};
            lcd_data <= frame[FRAME_BITS-1];
            lcd_cs   <= 1'b1;
            lcd_clk  <= 1'b0;
            ph_cnt   <= '0;
            bit_cnt  <= '0;
        end else if (lcd_cs) begin
            if (ph_cnt == PH_HALF) begin
                lcd_clk <= 1'b1;
                ph_cnt  <= ph_cnt + 1'b1;
            end else if (ph_cnt == PH_LAST) begin
                ph_cnt  <= '0;
                lcd_clk <= 1'b0;
                if (bit_cnt == BIT_LAST) begin
                    lcd_cs   <= 1'b0;
                    lcd_data <= 1'b0;
                    bit_cnt  <= '0;
                end else begin
                    lcd_data <= shreg[FRAME_BITS-1];
                    shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
                    bit_cnt  <= bit_cnt + 1'b1;
                end
            end else begin
                ph_cnt <= ph_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/st7920_cmd_scheduler.sv
// Round-robin arbiter of two command requesters onto one ST7920 serial link; frame starts the cycle after transfer.
// req_ready is combinational in IDLE only; each command holds the link for 48*CLK_DIV cycles plus a command-dependent gap.
module st7920_cmd_scheduler
    import st7920_pkg::*;
#(
    parameter int CLK_DIV    = 512,
    parameter int GAP_CYCLES = 3600,
    parameter int LONG_GAP   = 80000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] req_valid,
    input  logic [9:0] req_cmd0,
    input  logic [9:0] req_cmd1,
    output logic [1:0] req_ready,
    output logic       busy,
    output logic       lcd_cs,
    output logic       lcd_clk,
    output logic       lcd_data
);

    localparam int GAP_MAX = (LONG_GAP > GAP_CYCLES) ? LONG_GAP : GAP_CYCLES;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [GAP_W-1:0] NORM_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] LONG_LAST = GAP_W'(LONG_GAP - 1);

    sched_state_t     state;
    logic             prio;
    logic             long_gap;
    logic [GAP_W-1:0] gap_cnt;

    logic             pick1;
    logic             fire;
    logic             tx_done;
    st7920_cmd_t      sel_cmd;

    // A lone requester always wins; prio only breaks ties
    always_comb begin
        pick1 = 1'b0;
        if (req_valid == 2'b10)
            pick1 = 1'b1;
        else if (req_valid == 2'b11)
            pick1 = prio;
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == ST_IDLE && !sys_rst && (|req_valid))
            req_ready = pick1 ? 2'b10 : 2'b01;
    end

    assign fire    = |req_ready;
    assign sel_cmd = pick1 ? st7920_cmd_t'(req_cmd1) : st7920_cmd_t'(req_cmd0);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            prio     <= 1'b0;
            long_gap <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        state    <= ST_SHIFT;
                        prio     <= ~pick1;
                        long_gap <= is_long_cmd(sel_cmd);
                        gap_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (tx_done)
                        state <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == (long_gap ? LONG_LAST : NORM_LAST)) begin
                        state   <= ST_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    st7920_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_tx (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .start    (fire),
        .cmd      (sel_cmd),
        .done     (tx_done),
        .lcd_cs   (lcd_cs),
        .lcd_clk  (lcd_clk),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_st7920_cmd_scheduler.sv
// Directed bench for st7920_cmd_scheduler with CLK_DIV=2, GAP_CYCLES=4, LONG_GAP=10.
// Expected frames and gaps are queued when a command is driven and retired by a SID/CS monitor.
module tb_st7920_cmd_scheduler;

    localparam int CLK_DIV  = 2;
    localparam int GAP_N    = 4;
    localparam int GAP_L    = 10;
    localparam int FRAME_CY = 48 * CLK_DIV;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] req_valid;
    logic [9:0] req_cmd0;
    logic [9:0] req_cmd1;
    logic [1:0] req_ready;
    logic       busy;
    logic       lcd_cs;
    logic       lcd_clk;
    logic       lcd_data;

    st7920_cmd_scheduler #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_N),
        .LONG_GAP   (GAP_L)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_cmd0  (req_cmd0),
        .req_cmd1  (req_cmd1),
        .req_ready (req_ready),
        .busy      (busy),
        .lcd_cs    (lcd_cs),
        .lcd_clk   (lcd_clk),
        .lcd_data  (lcd_data)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [23:0] frame;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   g_who[$];
    int   g_cyc[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_frame(input logic [9:0] c);
        return {5'b11111, c[8], c[9], 1'b0, c[7:4], 4'b0000, c[3:0], 4'b0000};
    endfunction

    function automatic int model_gap(input logic [9:0] c);
        return (c[9:8] == 2'b00 && (c[7:0] == 8'h01 || c[7:0] == 8'h02 || c[7:0] == 8'h03))
               ? GAP_L : GAP_N;
    endfunction

    // Monitor
    logic [23:0] shreg;
    int   nbits, cs_len, gap_len, cur_gap;
    logic in_gap, prev_clk, prev_cs, prev_data;
    logic both_seen = 1'b0, data_bad = 1'b0, idle_bad = 1'b0, busy_bad = 1'b0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            shreg  = '0;
            nbits  = 0;
            cs_len = 0;
            in_gap = 1'b0;
            gap_len = 0;
        end else begin
            if (req_ready == 2'b11) both_seen = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    g_who.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (lcd_cs) begin
                cs_len++;
                if (!busy) busy_bad = 1'b1;
                if (lcd_clk && !prev_clk) begin
                    shreg = {shreg[22:0], lcd_data};
                    nbits++;
                end
            end
            if (lcd_clk && (lcd_data !== prev_data)) data_bad = 1'b1;
            if (!busy && (lcd_cs || lcd_clk || lcd_data)) idle_bad = 1'b1;
            if (prev_cs && !lcd_cs) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                    cur_gap = 0;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("frame_bits", 32'(shreg), 32'(e.frame));
                    check("sid_edges", 32'(nbits), 32'd24);
                    check("cs_cycles", 32'(cs_len), 32'(FRAME_CY));
                    cur_gap = e.gap;
                end
                in_gap  = 1'b1;
                gap_len = 0;
                nbits   = 0;
                cs_len  = 0;
            end
            if (in_gap && !lcd_cs) begin
                if (busy) gap_len++;
                else begin
                    check("gap_len", 32'(gap_len), 32'(cur_gap));
                    in_gap = 1'b0;
                end
            end
        end
        prev_clk  = lcd_clk;
        prev_cs   = lcd_cs;
        prev_data = lcd_data;
    end

    task automatic wait_ready(input int who);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge sys_clk);
            if (req_ready[who]) break;
        end
        if (n == 2000) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input int who, input logic [9:0] c);
        @(posedge sys_clk); #1;
        if (who == 0) req_cmd0 = c; else req_cmd1 = c;
        req_valid[who] = 1'b1;
        sb.push_back('{frame: model_frame(c), gap: model_gap(c)});
        wait_ready(who);
        @(posedge sys_clk); #1;
        req_valid[who] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge sys_clk);
            if (!busy && sb.size() == 0 && !in_gap) break;
        end
        if (n == 3000) check("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] cmd_seq [7];
        cmd_seq = '{10'h001, 10'h030, 10'h002, 10'h003, 10'h101, 10'h201, 10'h004};

        // Reset state, with both requesters asserting valid
        sys_rst   = 1'b1;
        req_valid = 2'b11;
        req_cmd0  = '0;
        req_cmd1  = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cs", 32'(lcd_cs), 32'd0);
        check("rst_clk", 32'(lcd_clk), 32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Reference frame: rs=1 rw=0 data=0x41, pushed as a literal bit pattern
        @(posedge sys_clk); #1;
        req_cmd0     = {1'b1, 1'b0, 8'h41};
        req_valid[0] = 1'b1;
        sb.push_back('{frame: 24'b11111_0_1_0_0100_0000_0001_0000, gap: GAP_N});
        wait_ready(0);
        @(posedge sys_clk); #1;
        req_valid[0] = 1'b0;
        wait_idle();

        // Clear/home versus normal gaps
        foreach (cmd_seq[i]) send(0, cmd_seq[i]);
        wait_idle();

        // Both requesters valid continuously from reset
        pulse_reset();
        g_who.delete();
        g_cyc.delete();
        @(posedge sys_clk); #1;
        req_cmd0  = {1'b1, 1'b0, 8'hA5};
        req_cmd1  = {1'b1, 1'b0, 8'h3C};
        req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{frame: model_frame(req_cmd0), gap: GAP_N});
            sb.push_back('{frame: model_frame(req_cmd1), gap: GAP_N});
        end
        for (int n = 0; n < 1000 && g_who.size() < 4; n++) @(negedge sys_clk);
        @(posedge sys_clk); #1;
        req_valid = 2'b00;
        wait_idle();
        check("rr_grants", 32'(g_who.size()), 32'd4);
        for (int i = 0; i < 4 && i < g_who.size(); i++)
            check("rr_order", 32'(g_who[i]), 32'(i % 2));
        for (int i = 0; i < 3 && i + 1 < g_cyc.size(); i++)
            check("rr_spacing", 32'(g_cyc[i+1] - g_cyc[i]), 32'(1 + FRAME_CY + GAP_N));

        // Lone req1 while the tie-break favours req0
        @(posedge sys_clk); #1;
        req_cmd1  = {1'b0, 1'b0, 8'h0C};
        req_valid = 2'b10;
        sb.push_back('{frame: model_frame(req_cmd1), gap: GAP_N});
        @(negedge sys_clk);
        check("lone_req1_ready", 32'(req_ready), 32'd2);
        @(posedge sys_clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Reset in the middle of bit 10
        @(posedge sys_clk); #1;
        req_cmd0  = {1'b1, 1'b0, 8'hFF};
        req_valid = 2'b01;
        sb.push_back('{frame: model_frame(req_cmd0), gap: GAP_N});
        @(negedge sys_clk);
        check("pre_abort_ready", 32'(req_ready), 32'd1);
        @(posedge sys_clk); #1;
        req_valid = 2'b00;
        repeat (41) @(posedge sys_clk);
        #1;
        check("mid_frame_cs", 32'(lcd_cs), 32'd1);
        sys_rst = 1'b1;
        #1;
        check("abort_cs", 32'(lcd_cs), 32'd0);
        check("abort_clk", 32'(lcd_clk), 32'd0);
        check("abort_data", 32'(lcd_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        void'(sb.pop_back());
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        send(0, 10'h030);
        wait_idle();

        check("ready_never_both", 32'(both_seen), 32'd0);
        check("sid_stable_clk_high", 32'(data_bad), 32'd0);
        check("idle_outputs_low", 32'(idle_bad), 32'd0);
        check("busy_during_frame", 32'(busy_bad), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/st7920_cmd_scheduler.md
ST7920_CMD_SCHEDULER -- requirements
Module: st7920_cmd_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CLK_DIV     512    sys_clk cycles per half period of lcd_clk
  GAP_CYCLES  3600   idle sys_clk cycles after a normal frame (72 us at 50 MHz)
  LONG_GAP    80000  idle sys_clk cycles after a clear/home frame (1.6 ms at 50 MHz)
REQ-002 Ports (name, direction, width, meaning), one per line:
  sys_clk    in   1   single clock; all logic on posedge
  sys_rst    in   1   reset, asynchronous, active-high
  req_valid  in   2   per-requester command valid
  req_cmd0   in   10  requester 0 command {rs, rw, data[7:0]}
  req_cmd1   in   10  requester 1 command {rs, rw, data[7:0]}
  req_ready  out  2   per-requester accept; one-hot or zero
  busy       out  1   high from acceptance until the end of the gap
  lcd_cs     out  1   ST7920 CS, high for the duration of a frame
  lcd_clk    out  1   ST7920 SCLK (E pin)
  lcd_data   out  1   ST7920 SID (R/W pin)

Function
REQ-003 The block SHALL arbitrate two requesters onto one ST7920 serial link, one 24-bit frame per accepted command.
REQ-004 The frame SHALL be sent MSB first as: 11111, rw, rs, 0, data[7:4], 0000, data[3:0], 0000.
REQ-005 States SHALL be IDLE, SHIFT and GAP; reset enters IDLE.
REQ-006 In IDLE, req_ready SHALL assert combinationally to the arbitration winner only; the transfer occurs on the cycle where valid and ready are both high.
REQ-007 In SHIFT and GAP, req_ready SHALL be 0.
REQ-008 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; after reset, requester 0 wins.
REQ-009 A single valid requester SHALL always be granted, regardless of the round-robin pointer.
REQ-010 Requesters SHALL hold req_valid and their command stable until ready is given; the block captures the command at transfer.
REQ-011 If transfer occurs in cycle T, then from T+1 through T+48*CLK_DIV lcd_cs SHALL be 1 and state SHALL be SHIFT.
REQ-012 Each bit SHALL occupy 2*CLK_DIV cycles:
  - lcd_clk low for the first CLK_DIV cycles, high for the second CLK_DIV cycles;
  - lcd_data changes only while lcd_clk is low, at the start of the bit.
REQ-013 After the 24th bit, lcd_cs, lcd_clk and lcd_data SHALL return to 0 and the state SHALL enter GAP.
REQ-014 GAP SHALL last LONG_GAP cycles when rs=0, rw=0 and data is 8'h01, 8'h02 or 8'h03; otherwise it SHALL last GAP_CYCLES cycles. The state then returns to IDLE.
REQ-015 The earliest next transfer SHALL be cycle T + 1 + 48*CLK_DIV + gap.
REQ-016 busy SHALL equal (state != IDLE).
REQ-017 In IDLE, lcd_cs, lcd_clk and lcd_data SHALL be 0.
REQ-018 Counter widths SHALL be derived from the parameters with $clog2; no counter may wrap within a frame or gap.

Reset
REQ-019 sys_rst high SHALL immediately force:
  - state IDLE, round-robin pointer to requester 0;
  - lcd_cs=0, lcd_clk=0, lcd_data=0, busy=0, req_ready=0;
  - all counters to 0.
REQ-020 Reset asserted mid-frame or mid-gap SHALL abandon the command with no retry; the first command after release SHALL start a fresh frame with its sync bits.

Structure
REQ-021 Package st7920_pkg SHALL hold:
  - typedef st7920_cmd_t {rs, rw, data[7:0]};
  - constants FRAME_BITS=24 and SYNC=5'b11111;
  - the clear/home opcode constants.
REQ-022 One sub-module, st7920_frame_tx, SHALL own the bit shifter and the lcd_clk/lcd_cs generation, with a start/done handshake to the arbiter FSM.

Verification (CLK_DIV=2, GAP_CYCLES=4, LONG_GAP=10)
REQ-023 req0 = {rs=1, rw=0, 8'h41}:
  - sampled SID at lcd_clk rising edges = 11111_0_1_0_0100_0000_0001_0000;
  - lcd_cs high for exactly 96 cycles.
REQ-024 Both requesters valid continuously from reset -> grants alternate 0,1,0,1, and consecutive req_ready pulses are exactly 101 cycles apart.
REQ-025 Clear and normal gaps:
  - req0 = 10'h001 then 10'h030 -> a 10-cycle gap after the first frame, a 4-cycle gap after the second;
  - busy falls exactly at the end of each gap.
REQ-026 sys_rst pulsed during bit 10 -> lcd_cs, lcd_clk, lcd_data, busy read 0 in the same cycle; the next accepted command begins with five 1 bits.
REQ-027 Only req1 valid, while the pointer favours req1's rival -> req1 granted in the same cycle; req_ready is never 2'b11 over the whole run.
